ex_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes M-extension operations from the ID/EX register outputs: valid bit, funct3, rs1/rs2 operand values.
- Holds the ID/EX register and upstream stages via a stall request until the 32-bit result is ready.
- Result goes to the EX/MEM writeback path.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/ex_muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: radix-2 shift-add multiply, restoring divide.
// Latency: 33 edges from accept to o_done for normal ops, 1 edge for divide-by-zero / signed overflow.
// Backpressure: o_stall holds ID/EX while an op is being accepted or iterated; i_flush abandons it.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid, i_op         M-extension op present in ID/EX, funct3 selector
//   i_rs1, i_rs2          operands (sampled only on the accept edge)
//   i_flush               drop any in-flight op, no result strobe
//   o_stall               stall request to pipeline control
//   o_done, o_result      one-cycle result strobe and the result (held until overwritten)
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ZERO    = '0;
    localparam logic [2*XLEN-1:0] ZERO2   = '0;
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // Multiply: {partial product hi, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;     // final result must be negated
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- accept-time decode ----------------
    logic            rs1_signed, rs2_signed, rs1_neg, rs2_neg, res_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] rs1_abs, rs2_abs, special_res;

    assign rs1_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    assign rs2_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    assign rs1_neg    = rs1_signed & i_rs1[XLEN-1];
    assign rs2_neg    = rs2_signed & i_rs2[XLEN-1];
    assign rs1_abs    = rs1_neg ? (ZERO - i_rs1) : i_rs1;
    assign rs2_abs    = rs2_neg ? (ZERO - i_rs2) : i_rs2;
    // Remainder follows the dividend; everything else is the XOR of operand signs
    // (unsigned ops have both sign flags clear).
    assign res_neg    = (i_op == 3'd6) ? rs1_neg : (rs1_neg ^ rs2_neg);

    assign div_zero   = i_op[2] && (i_rs2 == ZERO);
    assign div_ovf    = ((i_op == 3'd4) || (i_op == 3'd6)) && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    // i_op[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div_zero ? (i_op[1] ? i_rs1 : '1)
                                  : (i_op[1] ? ZERO : MIN_NEG);

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_fit;
    logic [2*XLEN-1:0] mul_step, div_step, step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {1'b0, ZERO});
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Shifted partial remainder can reach XLEN+1 bits; the compare uses all of them,
    // while the subtraction only needs XLEN bits because a fitting result is < divisor.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_fit   = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[XLEN-1:0] - opb_q;
    assign div_step  = {(div_fit ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_fit};

    assign step = op_q[2] ? div_step : mul_step;

    // ---------------- sign correction of the final iteration ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign prod_fix = neg_q ? (ZERO2 - step) : step;
    assign quo_fix  = neg_q ? (ZERO - step[XLEN-1:0]) : step[XLEN-1:0];
    assign rem_fix  = neg_q ? (ZERO - step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];

    always_comb begin
        final_res = rem_fix;
        case (op_q)
            3'd0:             final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quo_fix;
            default:          final_res = rem_fix;
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    op_d  = i_op;
                    neg_d = res_neg;
                    cnt_d = '1;
                    if (i_op[2]) begin
                        acc_d = {ZERO, rs1_abs};
                        opb_d = rs2_abs;
                    end else begin
                        acc_d = {ZERO, rs2_abs};
                        opb_d = rs1_abs;
                    end
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush wins over accept and over the final CALC->DONE step; the held result survives.
        if (i_flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_stall  = ((state_q == IDLE) && i_valid && !i_flush) || (state_q == CALC);
    assign o_done   = (state_q == DONE);
    assign o_result = result_q;

endmodule
